// File: rtl/pool2d_stream.sv
// Streaming 2x2 / stride-2 pooling unit (MAX or AVG, chosen per frame).
// Pixels arrive plane by plane in raster order; each odd-row/odd-col beat
// completes a window and loads the single-entry output register.
module pool2d_stream #(
    parameter int DATA_W   = 32,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int CHANNELS = 16,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    output logic                     busy,
    output logic                     done,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_last
);

    // Column counter is at least 2 bits so col[COL_W-1:1] is always a legal slice.
    localparam int COL_W = ($clog2(IMG_W) < 2) ? 2 : $clog2(IMG_W);
    localparam int ROW_W = ($clog2(IMG_H) < 1) ? 1 : $clog2(IMG_H);
    localparam int LB_N  = IMG_W / 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic             mode_q;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [CH_W-1:0]  ch;

    logic signed [DATA_W-1:0] h_reg;
    logic signed [DATA_W+1:0] linebuf [LB_N];

    logic                     accept, load;
    logic                     col_last, row_last, ch_last, frame_last;
    logic [COL_W-2:0]         lb_idx;
    logic signed [DATA_W:0]   h_ext, x_ext, pair;
    logic signed [DATA_W+1:0] pair_w, lb_q, vsum, vmax;
    logic signed [DATA_W-1:0] result;

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign col_last   = (col == COL_W'(IMG_W - 1));
    assign row_last   = (row == ROW_W'(IMG_H - 1));
    assign ch_last    = (ch == CH_W'(CHANNELS - 1));
    assign frame_last = col_last && row_last && ch_last;

    // A window completes on the odd column of an odd row.
    assign load   = accept && col[0] && row[0];
    assign lb_idx = col[COL_W-1:1];

    // Horizontal pair, then vertical combine against the stored upper pair.
    always_comb begin
        h_ext  = {h_reg[DATA_W-1], h_reg};
        x_ext  = {in_data[DATA_W-1], in_data};
        pair   = mode_q ? (h_ext + x_ext) : ((x_ext > h_ext) ? x_ext : h_ext);
        pair_w = {pair[DATA_W], pair};
        lb_q   = linebuf[lb_idx];
        vsum   = lb_q + pair_w;
        vmax   = (pair_w > lb_q) ? pair_w : lb_q;
        // Average of four DATA_W values always fits back into DATA_W bits.
        result = mode_q ? DATA_W'(vsum >>> 2) : DATA_W'(vmax);
    end

    // Frame FSM, mode latch and raster counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            mode_q <= 1'b0;
            col    <= '0;
            row    <= '0;
            ch     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        mode_q <= mode;
                        col    <= '0;
                        row    <= '0;
                        ch     <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (col_last) begin
                            col <= '0;
                            if (row_last) begin
                                row <= '0;
                                ch  <= ch_last ? '0 : ch + CH_W'(1);
                            end else begin
                                row <= row + ROW_W'(1);
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                        if (frame_last) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!out_valid || out_ready) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output register: reload wins over handshake clear so back-to-back has no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_ch    <= ch;
            out_last  <= row_last && col_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end
    end

    // Pixel holding register and line buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (accept && !col[0]) h_reg <= in_data;
        if (accept && col[0] && !row[0]) linebuf[lb_idx] <= pair_w;
    end

endmodule

// File: tb/tb_pool2d_stream.sv
// Bench for pool2d_stream: a 4x4x1 instance for the directed cases and a
// default-size instance for randomized full frames against a reference model.
module tb_pool2d_stream;

    localparam int DW  = 32;
    localparam int BN  = 28 * 28 * 16;
    localparam int BNO = 14 * 14 * 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // small instance: 4x4, one channel
    logic                 s_reset, s_start, s_mode, s_busy, s_done;
    logic                 s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
    logic signed [DW-1:0] s_in_data, s_out_data;
    logic [0:0]           s_out_ch;

    pool2d_stream #(.DATA_W(DW), .IMG_W(4), .IMG_H(4), .CHANNELS(1)) u_small (
        .clk(clk), .reset(s_reset), .start(s_start), .mode(s_mode),
        .busy(s_busy), .done(s_done),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_ch(s_out_ch), .out_last(s_out_last)
    );

    // default instance: 28x28, 16 channels
    logic                 b_reset, b_start, b_mode, b_busy, b_done;
    logic                 b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic signed [DW-1:0] b_in_data, b_out_data;
    logic [3:0]           b_out_ch;

    pool2d_stream u_big (
        .clk(clk), .reset(b_reset), .start(b_start), .mode(b_mode),
        .busy(b_busy), .done(b_done),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_ch(b_out_ch), .out_last(b_out_last)
    );

    int total = 0;
    int bad   = 0;

    longint img[$];
    longint exp_d[$];
    int     exp_c[$];
    bit     exp_l[$];
    longint got_d[$];
    int     got_c[$];
    bit     got_l[$];

    int done_cyc, last_hs_cyc, stall_rdy, stall_moved, stall_cnt;

    // Reference: pool each 2x2 window of every plane in ch / pooled-row / pooled-col order.
    function automatic void build_ref(input int w, input int h, input int nc, input bit md);
        longint a, b, c, d, s, v;
        exp_d.delete(); exp_c.delete(); exp_l.delete();
        for (int k = 0; k < nc; k++)
            for (int pr = 0; pr < h / 2; pr++)
                for (int pc = 0; pc < w / 2; pc++) begin
                    a = img[(k * h + 2 * pr) * w + 2 * pc];
                    b = img[(k * h + 2 * pr) * w + 2 * pc + 1];
                    c = img[(k * h + 2 * pr + 1) * w + 2 * pc];
                    d = img[(k * h + 2 * pr + 1) * w + 2 * pc + 1];
                    if (md) begin
                        s = a + b + c + d;
                        v = (s >= 0) ? s / 4 : -((-s + 3) / 4);
                    end else begin
                        v = a;
                        if (b > v) v = b;
                        if (c > v) v = c;
                        if (d > v) v = d;
                    end
                    exp_d.push_back(v);
                    exp_c.push_back(k);
                    exp_l.push_back((pr == h / 2 - 1) && (pc == w / 2 - 1));
                end
    endfunction

    function automatic void clear_got();
        got_d.delete(); got_c.delete(); got_l.delete();
    endfunction

    // Drive img[] through the small instance; out_ready is held low for `stall`
    // cycles in which a result is waiting.
    task automatic run_small(input bit md, input int stall, input int vld_pct);
        int idx, cyc, stall_left;
        bit held;
        logic signed [DW-1:0] hold_d;
        logic [0:0] hold_c;
        idx = 0; cyc = 0; stall_left = stall; held = 0; hold_d = '0; hold_c = '0;
        done_cyc = -1; last_hs_cyc = -1; stall_rdy = 0; stall_moved = 0; stall_cnt = 0;
        clear_got();
        @(negedge clk); s_mode = md; s_start = 1'b1;
        @(negedge clk); s_start = 1'b0; s_mode = ~md;
        while (done_cyc < 0 && cyc < 400) begin
            @(negedge clk);
            s_in_valid  = (idx < img.size()) && ($urandom_range(0, 99) < vld_pct);
            s_in_data   = (idx < img.size()) ? DW'(img[idx]) : '0;
            s_out_ready = (stall_left == 0);
            #1;
            if (s_done) done_cyc = cyc;
            if (s_out_valid && !s_out_ready) begin
                if (!held) begin held = 1; hold_d = s_out_data; hold_c = s_out_ch; end
                if (s_in_ready) stall_rdy++;
                if (s_out_data !== hold_d || s_out_ch !== hold_c) stall_moved++;
                stall_left--;
                stall_cnt++;
            end
            if (s_out_valid && s_out_ready) begin
                got_d.push_back(longint'(s_out_data));
                got_c.push_back(int'(s_out_ch));
                got_l.push_back(s_out_last);
                if (got_d.size() == 4) last_hs_cyc = cyc;
            end
            if (s_in_valid && s_in_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        s_in_valid = 1'b0; s_out_ready = 1'b0;
    endtask

    task automatic run_big(input bit md);
        int idx, cyc;
        idx = 0; cyc = 0; done_cyc = -1;
        clear_got();
        @(negedge clk); b_mode = md; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        while (done_cyc < 0 && cyc < 30000) begin
            @(negedge clk);
            // stray start pulses with a random mode while the frame is running
            b_start     = (idx < BN) && ($urandom_range(0, 99) < 2);
            b_mode      = 1'($urandom_range(0, 1));
            b_in_valid  = (idx < BN) && ($urandom_range(0, 99) < 80);
            b_in_data   = (idx < BN) ? DW'(img[idx]) : '0;
            b_out_ready = ($urandom_range(0, 99) < 75);
            #1;
            if (b_done) done_cyc = cyc;
            if (b_out_valid && b_out_ready) begin
                got_d.push_back(longint'(b_out_data));
                got_c.push_back(int'(b_out_ch));
                got_l.push_back(b_out_last);
            end
            if (b_in_valid && b_in_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        b_start = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    endtask

    function automatic void ramp_img();
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(longint'(i));
    endfunction

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        total++;
        if ({s_busy, s_done, s_in_ready, s_out_valid, s_out_last} !== 5'b0 || s_out_data !== '0 || s_out_ch !== '0) begin
            bad++;
            $display("FAIL reset_small: busy=%b done=%b in_ready=%b out_valid=%b data=%0d want all 0",
                     s_busy, s_done, s_in_ready, s_out_valid, s_out_data);
        end
        total++;
        if ({b_busy, b_done, b_in_ready, b_out_valid, b_out_last} !== 5'b0 || b_out_data !== '0 || b_out_ch !== '0) begin
            bad++;
            $display("FAIL reset_big: busy=%b done=%b in_ready=%b out_valid=%b data=%0d want all 0",
                     b_busy, b_done, b_in_ready, b_out_valid, b_out_data);
        end
        s_reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);
    endtask

    // Directed 4x4 result check against spec-given values.
    task automatic check_four(input string nm, input longint e0, input longint e1,
                              input longint e2, input longint e3);
        longint e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        total++;
        if (got_d.size() != 4) begin
            bad++;
            $display("FAIL %s_count: got %0d results want 4", nm, got_d.size());
        end
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== e[i] || got_l[i] !== (i == 3)) begin
                bad++;
                $display("FAIL %s_out%0d: data=%0d last=%b want data=%0d last=%b",
                         nm, i, got_d[i], got_l[i], e[i], (i == 3));
            end
        end
    endtask

    task automatic test_max_ramp();
        ramp_img();
        run_small(1'b0, 0, 100);
        check_four("max_ramp", 5, 7, 13, 15);
        total++;
        if (last_hs_cyc < 0 || done_cyc !== last_hs_cyc + 1) begin
            bad++;
            $display("FAIL done_timing: done at cycle %0d want %0d", done_cyc, last_hs_cyc + 1);
        end
    endtask

    task automatic test_avg_ramp();
        ramp_img();
        run_small(1'b1, 0, 70);
        check_four("avg_ramp", 2, 4, 10, 12);
    endtask

    task automatic test_signed_edges();
        for (int m = 1; m >= 0; m--) begin
            img.delete();
            for (int i = 0; i < 16; i++) img.push_back(longint'($signed($urandom())));
            img[0] = -1; img[1] = -2; img[4] = -3; img[5] = -4;
            img[2] = 2147483647; img[3] = 2147483647; img[6] = 2147483647; img[7] = 2147483647;
            run_small(m[0], 0, 100);
            build_ref(4, 4, 1, m[0]);
            check_four(m[0] ? "avg_signed" : "max_signed", exp_d[0], exp_d[1], exp_d[2], exp_d[3]);
            total++;
            if (got_d.size() < 2 || got_d[0] !== (m[0] ? -3 : -1) || got_d[1] !== 2147483647) begin
                bad++;
                $display("FAIL signed_win_m%0d: got %0d,%0d want %0d,2147483647", m,
                         (got_d.size() > 0) ? got_d[0] : 0, (got_d.size() > 1) ? got_d[1] : 0,
                         m[0] ? -3 : -1);
            end
        end
    endtask

    task automatic test_backpressure();
        ramp_img();
        run_small(1'b0, 5, 100);
        total++;
        if (stall_cnt !== 5 || stall_rdy !== 0 || stall_moved !== 0) begin
            bad++;
            $display("FAIL stall: cycles=%0d in_ready_hi=%0d changes=%0d want 5,0,0",
                     stall_cnt, stall_rdy, stall_moved);
        end
        check_four("stall", 5, 7, 13, 15);
    endtask

    task automatic test_mid_reset();
        int acc, cyc;
        acc = 0; cyc = 0;
        @(negedge clk); s_mode = 1'b0; s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        while (acc < 7 && cyc < 50) begin
            @(negedge clk);
            s_in_valid = 1'b1; s_in_data = DW'(100 + acc); s_out_ready = 1'b1;
            #1;
            if (s_in_ready) acc++;
            cyc++;
        end
        @(negedge clk);
        s_in_valid = 1'b0; s_out_ready = 1'b0;
        total++;
        if (acc != 7 || s_busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_frame: beats=%0d busy=%b want 7,1", acc, s_busy);
        end
        s_reset = 1'b1;
        #1;
        total++;
        if ({s_busy, s_done, s_in_ready, s_out_valid, s_out_last} !== 5'b0 || s_out_data !== '0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b in_ready=%b out_valid=%b data=%0d want 0",
                     s_busy, s_in_ready, s_out_valid, s_out_data);
        end
        @(negedge clk); s_reset = 1'b0;
        ramp_img();
        run_small(1'b0, 0, 100);
        check_four("post_reset", 5, 7, 13, 15);
    endtask

    task automatic test_random_frames();
        int derr, cerr, lcnt, first;
        for (int m = 0; m < 2; m++) begin
            img.delete();
            for (int i = 0; i < BN; i++) img.push_back(longint'($signed($urandom())));
            build_ref(28, 28, 16, m[0]);
            run_big(m[0]);
            derr = 0; cerr = 0; lcnt = 0; first = -1;
            for (int i = 0; i < got_d.size() && i < BNO; i++) begin
                if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                    derr++;
                    if (first < 0) first = i;
                end
                if (got_c[i] !== exp_c[i]) cerr++;
                if (got_l[i]) lcnt++;
            end
            total++;
            if (done_cyc < 0 || got_d.size() != BNO) begin
                bad++;
                $display("FAIL rand_m%0d_count: results=%0d done_cyc=%0d want %0d results and done",
                         m, got_d.size(), done_cyc, BNO);
            end
            total++;
            if (derr != 0) begin
                bad++;
                $display("FAIL rand_m%0d_data: %0d wrong, first idx %0d got %0d want %0d",
                         m, derr, first, got_d[first], exp_d[first]);
            end
            total++;
            if (cerr != 0 || lcnt != 16) begin
                bad++;
                $display("FAIL rand_m%0d_ch: ch errors=%0d last count=%0d want 0,16", m, cerr, lcnt);
            end
        end
    endtask

    initial begin
        s_reset = 1'b1; s_start = 1'b0; s_mode = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
        b_reset = 1'b1; b_start = 1'b0; b_mode = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        test_reset();
        test_max_ramp();
        test_avg_ramp();
        test_signed_edges();
        test_backpressure();
        test_mid_reset();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
